capture_ctl: RTL and testbench
==============================

# capture_ctl

Sample capture controller sitting directly downstream of the `trigger` block. It consumes the trigger's output stream (sample data plus per-sample event flags) and keeps a pre-trigger history in a circular buffer. On a masked event it records a programmed number of post-trigger samples, then streams the captured window out, oldest sample first, to the readout path.

## Interface
Parameters:
- `SDW`, 32, sample data width
- `SEW`, 8, event width (matches the trigger output event width)
- `BAW`, 10, buffer address width; depth `2**BAW` samples

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-low (asserted when 0)
- `cfg_arm`  in  1  single-cycle arm request
- `cfg_abort`  in  1  single-cycle abort request
- `cfg_mask`  in  SEW  event mask; trigger = |(sti_tevent & mask)
- `cfg_pre`  in  BAW  pre-trigger sample count
- `cfg_post`  in  BAW+1  post-trigger count, including the trigger sample
- `sti_tready`  out  1  input stream ready
- `sti_tvalid`  in  1  input stream valid
- `sti_tevent`  in  SEW  event flags of the current sample
- `sti_tdata`  in  SDW  sample data
- `sto_tready`  in  1  output stream ready
- `sto_tvalid`  out  1  output stream valid
- `sto_tdata`  out  SDW  captured sample
- `sto_tlast`  out  1  marks the final captured sample
- `sts_state`  out  3  current state encoding
- `sts_trg_adr`  out  BAW  buffer address of the trigger sample

## Operation
- Buffer: simple dual-port RAM, `2**BAW` x `SDW`, synchronous read, 1-cycle latency. Write pointer `wpt` wraps modulo `2**BAW`.
- Input transfer: `sti_tready & sti_tvalid`.
  - `sti_tready` = 1 in every state after reset.
  - Samples transferred outside FILL/WAIT/POST are discarded. Upstream is never stalled.
- `cfg_mask`, `cfg_pre` and `cfg_post` are latched on an accepted `cfg_arm`.
  - `cfg_post` = 0 is latched as 1.
  - Software guarantees `cfg_pre + cfg_post <= 2**BAW`; behaviour outside this is undefined.
- States (`sts_state`): IDLE=0, FILL=1, WAIT=2, POST=3, READ=4.
- IDLE: on `cfg_arm` -> FILL, with `wpt`=0 and fill counter=0. If the latched `cfg_pre`=0, go directly to WAIT.
- FILL: each transfer writes to `wpt` and increments `wpt` and the counter. Events are ignored. On the transfer that makes counter == `cfg_pre` -> WAIT.
- WAIT: each transfer writes and increments `wpt`.
  - A transfer with a masked event becomes the trigger sample: `sts_trg_adr`<=`wpt`, post counter<=1.
  - If `cfg_post`==1, go directly to READ; otherwise -> POST.
- POST: each transfer writes and increments the post counter. The transfer that makes it equal to `cfg_post` -> READ. Events are ignored.
- READ:
  - Read pointer starts at `sts_trg_adr - cfg_pre` (mod `2**BAW`). Total beats = `cfg_pre + cfg_post`.
  - Standard valid/ready: `sto_tdata`/`sto_tlast` are held stable while `sto_tvalid & ~sto_tready`.
  - `sto_tlast`=1 only on the final beat. Its acceptance -> IDLE.
- `cfg_abort` in any state: -> IDLE on the next edge; `sto_tvalid`, `sto_tlast` <= 0. Abort has priority over a simultaneous `cfg_arm` or trigger.
- `cfg_arm` outside IDLE is ignored.

## Timing
- Reset values: `sti_tready`=0 during reset, 1 from the first edge after release. `sto_tvalid`=0, `sto_tdata`=0, `sto_tlast`=0, `sts_state`=0, `sts_trg_adr`=0.
- Arm-to-capture latency: the first sample eligible for writing is the one transferred on the edge after `cfg_arm` is sampled.
- Trigger decision is same-cycle: the event-carrying sample itself is stored as trigger sample.
- READ entry: state changes on the edge of the final post transfer. The first `sto_tvalid`=1 occurs 2 edges later (one RAM read cycle).
- Throughput: 1 beat per cycle while `sto_tready`=1, with no bubbles. A `sto_tready` deassert/reassert causes no lost or duplicated beat; a prefetch/skid register is required.
- Reset asserted mid-capture or mid-readout: immediate return to reset values. RAM contents are don't-care.

## Test plan
- Basic capture: BAW=4, pre=3, post=2, mask=0x01. Feed data 0..15 with event on sample 7 -> state 1,2,3,4,0; `sts_trg_adr`=7; output 4,5,6,7,8 with `sto_tlast` on 8.
- Wrap-around: pre=10, post=6, trigger at sample 20 -> output 10..25 in order; `sts_trg_adr`=4; exactly 16 beats.
- Early event ignored: pre=4, event on samples 1 and 6 -> trigger taken at 6; output 2..6 (post=1), `sto_tlast` on 6.
- Backpressure: random `sto_tready` at 50% during READ -> identical sequence to the no-stall run; data stable while stalled.
- Abort and arm collision: `cfg_abort` together with `cfg_arm` in WAIT -> IDLE next cycle, `sto_tvalid` stays 0. A later arm captures correctly.
- Corner values and reset: pre=0, post=0 (treated as 1) -> single beat equal to the trigger sample with `sto_tlast`=1. Async reset pulse during READ -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/capture_ctl.sv
`default_nettype none
// ============================================================================
// capture_ctl : pre/post-trigger sample capture into a circular buffer, then
//               oldest-first readout over a valid/ready stream.  Rev 1.0
// ============================================================================
module capture_ctl #(
    parameter int SDW = 32,
    parameter int SEW = 8,
    parameter int BAW = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_arm,
    input  logic           cfg_abort,
    input  logic [SEW-1:0] cfg_mask,
    input  logic [BAW-1:0] cfg_pre,
    input  logic [BAW:0]   cfg_post,
    output logic           sti_tready,
    input  logic           sti_tvalid,
    input  logic [SEW-1:0] sti_tevent,
    input  logic [SDW-1:0] sti_tdata,
    input  logic           sto_tready,
    output logic           sto_tvalid,
    output logic [SDW-1:0] sto_tdata,
    output logic           sto_tlast,
    output logic [2:0]     sts_state,
    output logic [BAW-1:0] sts_trg_adr
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FILL = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_READ = 3'd4
    } state_t;

    localparam logic [BAW:0]   c_cnt_one = {{BAW{1'b0}}, 1'b1};
    localparam logic [BAW-1:0] c_adr_one = {{(BAW-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             rdy_q;
    logic [BAW-1:0]   wpt_q, wpt_d;
    logic [BAW:0]     cnt_q, cnt_d;
    logic [BAW-1:0]   pre_q, pre_d;
    logic [BAW:0]     post_q, post_d;
    logic [SEW-1:0]   mask_q, mask_d;
    logic [BAW-1:0]   trg_q, trg_d;
    logic [BAW-1:0]   rpt_q, rpt_d;
    logic [BAW:0]     rem_q, rem_d;
    logic             rdv_q, rdv_d;
    logic             rdl_q, rdl_d;
    logic             ovld_q, ovld_d;
    logic             olast_q, olast_d;
    logic [SDW-1:0]   odata_q, odata_d;
    logic             svld_q, svld_d;
    logic             slast_q, slast_d;
    logic [SDW-1:0]   sdata_q, sdata_d;

    logic [SDW-1:0]   mem_q [0:(1<<BAW)-1];
    logic [SDW-1:0]   ram_q;

    logic             w_xfer;
    logic             w_hit;
    logic             w_wr;
    logic             w_pop;
    logic             w_issue;
    logic [2:0]       w_occ;
    logic [BAW-1:0]   w_wpt_inc;
    logic [BAW:0]     w_cnt_inc;
    logic [BAW:0]     w_total;

    assign w_xfer    = rdy_q & sti_tvalid;
    assign w_hit     = |(sti_tevent & mask_q);
    assign w_wr      = w_xfer & ((state_q == S_FILL) | (state_q == S_WAIT) | (state_q == S_POST));
    assign w_wpt_inc = wpt_q + c_adr_one;
    assign w_cnt_inc = cnt_q + c_cnt_one;
    assign w_total   = {1'b0, pre_q} + post_q;
    assign w_pop     = ovld_q & sto_tready;

    // Beats held in output reg, skid reg and the RAM read in flight; a read is
    // only issued when its data is guaranteed a slot on arrival.
    assign w_occ   = {2'b00, ovld_q} + {2'b00, svld_q} + {2'b00, rdv_q};
    assign w_issue = (state_q == S_READ) & (rem_q != '0) & ((w_occ - {2'b00, w_pop}) < 3'd2);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            mem_q[wpt_q] <= sti_tdata;
        end
        if (w_issue) begin
            ram_q <= mem_q[rpt_q];
        end
    end

    always_comb begin
        state_d = state_q;
        wpt_d   = wpt_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        post_d  = post_q;
        mask_d  = mask_q;
        trg_d   = trg_q;
        rpt_d   = rpt_q;
        rem_d   = rem_q;
        rdv_d   = 1'b0;
        rdl_d   = rdl_q;
        ovld_d  = ovld_q;
        olast_d = olast_q;
        odata_d = odata_q;
        svld_d  = svld_q;
        slast_d = slast_q;
        sdata_d = sdata_q;

        if (cfg_abort) begin
            state_d = S_IDLE;
            ovld_d  = 1'b0;
            olast_d = 1'b0;
            svld_d  = 1'b0;
            rem_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cfg_arm) begin
                        mask_d  = cfg_mask;
                        pre_d   = cfg_pre;
                        post_d  = (cfg_post == '0) ? c_cnt_one : cfg_post;
                        wpt_d   = '0;
                        cnt_d   = '0;
                        state_d = (cfg_pre == '0) ? S_WAIT : S_FILL;
                    end
                end
                S_FILL: begin
                    if (w_xfer) begin
                        wpt_d = w_wpt_inc;
                        cnt_d = w_cnt_inc;
                        if (w_cnt_inc == {1'b0, pre_q}) begin
                            state_d = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_xfer) begin
                        wpt_d = w_wpt_inc;
                        if (w_hit) begin
                            trg_d = wpt_q;
                            cnt_d = c_cnt_one;
                            if (post_q == c_cnt_one) begin
                                state_d = S_READ;
                                rpt_d   = wpt_q - pre_q;
                                rem_d   = w_total;
                            end else begin
                                state_d = S_POST;
                            end
                        end
                    end
                end
                S_POST: begin
                    if (w_xfer) begin
                        wpt_d = w_wpt_inc;
                        cnt_d = w_cnt_inc;
                        if (w_cnt_inc == post_q) begin
                            state_d = S_READ;
                            rpt_d   = trg_q - pre_q;
                            rem_d   = w_total;
                        end
                    end
                end
                S_READ: begin
                    if (w_issue) begin
                        rpt_d = rpt_q + c_adr_one;
                        rem_d = rem_q - c_cnt_one;
                        rdv_d = 1'b1;
                        rdl_d = (rem_q == c_cnt_one);
                    end
                    if (w_pop && olast_q) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // Output register refills from skid first to keep beat order.
            if (!ovld_q || sto_tready) begin
                if (svld_q) begin
                    ovld_d  = 1'b1;
                    odata_d = sdata_q;
                    olast_d = slast_q;
                    svld_d  = rdv_q;
                    if (rdv_q) begin
                        sdata_d = ram_q;
                        slast_d = rdl_q;
                    end
                end else if (rdv_q) begin
                    ovld_d  = 1'b1;
                    odata_d = ram_q;
                    olast_d = rdl_q;
                end else begin
                    ovld_d  = 1'b0;
                    olast_d = 1'b0;
                end
            end else if (rdv_q) begin
                svld_d  = 1'b1;
                sdata_d = ram_q;
                slast_d = rdl_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            rdy_q   <= 1'b0;
            wpt_q   <= '0;
            cnt_q   <= '0;
            pre_q   <= '0;
            post_q  <= '0;
            mask_q  <= '0;
            trg_q   <= '0;
            rpt_q   <= '0;
            rem_q   <= '0;
            rdv_q   <= 1'b0;
            rdl_q   <= 1'b0;
            ovld_q  <= 1'b0;
            olast_q <= 1'b0;
            odata_q <= '0;
            svld_q  <= 1'b0;
            slast_q <= 1'b0;
            sdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            wpt_q   <= wpt_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            post_q  <= post_d;
            mask_q  <= mask_d;
            trg_q   <= trg_d;
            rpt_q   <= rpt_d;
            rem_q   <= rem_d;
            rdv_q   <= rdv_d;
            rdl_q   <= rdl_d;
            ovld_q  <= ovld_d;
            olast_q <= olast_d;
            odata_q <= odata_d;
            svld_q  <= svld_d;
            slast_q <= slast_d;
            sdata_q <= sdata_d;
        end
    end

    assign sti_tready  = rdy_q;
    assign sto_tvalid  = ovld_q;
    assign sto_tdata   = odata_q;
    assign sto_tlast   = olast_q;
    assign sts_state   = state_q;
    assign sts_trg_adr = trg_q;

endmodule

`default_nettype wire

// File: tb/tb_capture_ctl.sv
`default_nettype none
// ============================================================================
// tb_capture_ctl : randomized capture runs against a window-based reference.
// Rev 1.0
// ============================================================================
module tb_capture_ctl;

    localparam int SDW   = 32;
    localparam int SEW   = 8;
    localparam int BAW   = 4;
    localparam int DEPTH = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           cfg_arm;
    logic           cfg_abort;
    logic [SEW-1:0] cfg_mask;
    logic [BAW-1:0] cfg_pre;
    logic [BAW:0]   cfg_post;
    logic           sti_tready;
    logic           sti_tvalid;
    logic [SEW-1:0] sti_tevent;
    logic [SDW-1:0] sti_tdata;
    logic           sto_tready;
    logic           sto_tvalid;
    logic [SDW-1:0] sto_tdata;
    logic           sto_tlast;
    logic [2:0]     sts_state;
    logic [BAW-1:0] sts_trg_adr;

    int total = 0;
    int bad   = 0;

    logic [31:0] dat[$];
    logic [7:0]  ev[$];

    capture_ctl #(.SDW(SDW), .SEW(SEW), .BAW(BAW)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_arm     (cfg_arm),
        .cfg_abort   (cfg_abort),
        .cfg_mask    (cfg_mask),
        .cfg_pre     (cfg_pre),
        .cfg_post    (cfg_post),
        .sti_tready  (sti_tready),
        .sti_tvalid  (sti_tvalid),
        .sti_tevent  (sti_tevent),
        .sti_tdata   (sti_tdata),
        .sto_tready  (sto_tready),
        .sto_tvalid  (sto_tvalid),
        .sto_tdata   (sto_tdata),
        .sto_tlast   (sto_tlast),
        .sts_state   (sts_state),
        .sts_trg_adr (sts_trg_adr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic seq_ramp(input int n);
        dat.delete();
        ev.delete();
        for (int k = 0; k < n; k++) begin
            dat.push_back(32'(k));
            ev.push_back(8'h00);
        end
    endtask

    task automatic seq_rand(input int n);
        dat.delete();
        ev.delete();
        for (int k = 0; k < n; k++) begin
            dat.push_back($urandom);
            ev.push_back(8'h00);
        end
    endtask

    // Reference: the trigger is the first masked sample at index >= pre;
    // the captured window is samples [t-pre, t+post) in arrival order.
    task automatic run_capture(input int pre, input int post, input logic [7:0] mask,
                               input int vpct, input int rpct, input string tag);
        int          postx;
        int          t;
        logic [31:0] expq[$];
        int          exp_st[$];
        int          seen_st[$];
        logic [31:0] got[$];
        logic        gotl[$];
        int          fi;
        int          cyc;
        int          n_read;
        int          n_vld;
        int          bubbles;
        int          prev_st;
        bit          done;
        bit          pv;
        bit          pr;
        logic [31:0] pd;
        logic        pl;

        postx = (post == 0) ? 1 : post;
        t = -1;
        for (int k = pre; k < dat.size(); k++) begin
            if ((ev[k] & mask) != 8'h00) begin
                t = k;
                break;
            end
        end
        if (t >= 0) begin
            for (int k = t - pre; k < t + postx; k++) expq.push_back(dat[k]);
        end
        if (pre > 0) exp_st.push_back(1);
        exp_st.push_back(2);
        if (postx > 1) exp_st.push_back(3);
        exp_st.push_back(4);
        exp_st.push_back(0);

        @(negedge clk);
        cfg_arm  = 1'b1;
        cfg_pre  = 4'(pre);
        cfg_post = 5'(post);
        cfg_mask = mask;
        @(negedge clk);
        cfg_arm  = 1'b0;

        fi = 0; cyc = 0; n_read = -1; n_vld = -1; bubbles = 0; prev_st = 0;
        done = 1'b0; pv = 1'b0; pr = 1'b0; pd = '0; pl = 1'b0;
        while (!done && cyc < 3000) begin
            if (int'(sts_state) != prev_st) begin
                prev_st = int'(sts_state);
                seen_st.push_back(prev_st);
                if (prev_st == 4 && n_read < 0) n_read = cyc;
            end
            if (sto_tvalid && n_vld < 0) n_vld = cyc;
            if (pv && !pr) begin
                chk({tag, "_hold_vld"}, 64'(sto_tvalid), 64'(1));
                chk({tag, "_hold_dat"}, 64'(sto_tdata), 64'(pd));
                chk({tag, "_hold_last"}, 64'(sto_tlast), 64'(pl));
            end
            if (n_vld >= 0 && !sto_tvalid) bubbles++;

            sto_tready = (int'($urandom_range(99)) < rpct);
            if (fi < dat.size() && int'($urandom_range(99)) < vpct) begin
                sti_tvalid = 1'b1;
                sti_tdata  = dat[fi];
                sti_tevent = ev[fi];
                fi++;
            end else begin
                sti_tvalid = 1'b0;
                sti_tdata  = $urandom;
                sti_tevent = 8'hFF;
            end
            if (sto_tvalid && sto_tready) begin
                got.push_back(sto_tdata);
                gotl.push_back(sto_tlast);
                if (sto_tlast) done = 1'b1;
            end
            pv = sto_tvalid; pr = sto_tready; pd = sto_tdata; pl = sto_tlast;
            @(negedge clk);
            cyc++;
        end
        if (int'(sts_state) != prev_st) seen_st.push_back(int'(sts_state));
        sti_tvalid = 1'b0;
        sto_tready = 1'b0;

        chk({tag, "_done"}, 64'(done), 64'(1));
        chk({tag, "_beats"}, 64'(got.size()), 64'(expq.size()));
        for (int i = 0; i < got.size() && i < expq.size(); i++) begin
            chk($sformatf("%s_d%0d", tag, i), 64'(got[i]), 64'(expq[i]));
            chk($sformatf("%s_l%0d", tag, i), 64'(gotl[i]), 64'(i == expq.size() - 1));
        end
        chk({tag, "_nstates"}, 64'(seen_st.size()), 64'(exp_st.size()));
        for (int i = 0; i < seen_st.size() && i < exp_st.size(); i++) begin
            chk($sformatf("%s_st%0d", tag, i), 64'(seen_st[i]), 64'(exp_st[i]));
        end
        chk({tag, "_trg"}, 64'(sts_trg_adr), 64'(t % DEPTH));
        chk({tag, "_lat"}, 64'(n_vld - n_read), 64'(2));
        if (rpct == 100) chk({tag, "_bubbles"}, 64'(bubbles), 64'(0));
        chk({tag, "_idle_vld"}, 64'(sto_tvalid), 64'(0));
    endtask

    initial begin
        int          p;
        int          q;
        logic [7:0]  m;

        rst        = 1'b0;
        cfg_arm    = 1'b0;
        cfg_abort  = 1'b0;
        cfg_mask   = '0;
        cfg_pre    = '0;
        cfg_post   = '0;
        sti_tvalid = 1'b0;
        sti_tevent = '0;
        sti_tdata  = '0;
        sto_tready = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_rdy", 64'(sti_tready), 64'(0));
        chk("rst_vld", 64'(sto_tvalid), 64'(0));
        chk("rst_dat", 64'(sto_tdata), 64'(0));
        chk("rst_last", 64'(sto_tlast), 64'(0));
        chk("rst_state", 64'(sts_state), 64'(0));
        chk("rst_trg", 64'(sts_trg_adr), 64'(0));
        rst = 1'b1;
        #1;
        chk("rel_rdy0", 64'(sti_tready), 64'(0));
        @(negedge clk);
        chk("rel_rdy1", 64'(sti_tready), 64'(1));

        // Basic capture
        seq_ramp(16);
        ev[7] = 8'h01;
        run_capture(3, 2, 8'h01, 100, 100, "basic");

        // Wrap-around
        seq_ramp(30);
        ev[20] = 8'h01;
        run_capture(10, 6, 8'h01, 100, 100, "wrap");

        // Early event ignored during fill
        seq_ramp(16);
        ev[1] = 8'h01;
        ev[6] = 8'h01;
        run_capture(4, 1, 8'h01, 100, 100, "early");

        // Backpressure with input gaps
        seq_rand(30);
        ev[20] = 8'h01;
        run_capture(10, 6, 8'h01, 70, 50, "bkp");

        // Abort colliding with arm while waiting for trigger
        @(negedge clk);
        cfg_arm = 1'b1; cfg_pre = 4'd2; cfg_post = 5'd3; cfg_mask = 8'h02;
        @(negedge clk);
        cfg_arm = 1'b0;
        repeat (4) begin
            sti_tvalid = 1'b1; sti_tdata = $urandom; sti_tevent = 8'h00;
            @(negedge clk);
        end
        chk("abort_pre_state", 64'(sts_state), 64'(2));
        cfg_abort = 1'b1; cfg_arm = 1'b1; sti_tevent = 8'h02;
        @(negedge clk);
        cfg_abort = 1'b0; cfg_arm = 1'b0;
        chk("abort_state", 64'(sts_state), 64'(0));
        chk("abort_vld", 64'(sto_tvalid), 64'(0));
        repeat (8) @(negedge clk);
        sti_tvalid = 1'b0;
        chk("abort_stay_state", 64'(sts_state), 64'(0));
        chk("abort_stay_vld", 64'(sto_tvalid), 64'(0));
        seq_rand(24);
        ev[9] = 8'h02;
        run_capture(5, 3, 8'h02, 100, 100, "rearm");

        // Corner: pre=0, post=0 treated as 1
        seq_rand(16);
        ev[3] = 8'h80;
        run_capture(0, 0, 8'h80, 100, 100, "corner");

        // Async reset during readout
        seq_ramp(20);
        ev[5] = 8'h04;
        @(negedge clk);
        cfg_arm = 1'b1; cfg_pre = 4'd3; cfg_post = 5'd4; cfg_mask = 8'h04;
        @(negedge clk);
        cfg_arm = 1'b0;
        sto_tready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            sti_tvalid = 1'b1; sti_tdata = dat[k]; sti_tevent = ev[k];
            @(negedge clk);
        end
        sti_tvalid = 1'b0;
        chk("rdrst_state", 64'(sts_state), 64'(4));
        chk("rdrst_vld", 64'(sto_tvalid), 64'(1));
        chk("rdrst_dat", 64'(sto_tdata), 64'(2));
        #1 rst = 1'b0;
        #1;
        chk("rdrst_rdy", 64'(sti_tready), 64'(0));
        chk("rdrst_vld0", 64'(sto_tvalid), 64'(0));
        chk("rdrst_dat0", 64'(sto_tdata), 64'(0));
        chk("rdrst_last0", 64'(sto_tlast), 64'(0));
        chk("rdrst_state0", 64'(sts_state), 64'(0));
        chk("rdrst_trg0", 64'(sts_trg_adr), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rdrst_rdy1", 64'(sti_tready), 64'(1));

        // Random captures
        for (int r = 0; r < 6; r++) begin
            p = int'($urandom_range(15));
            q = int'($urandom_range(16 - p));
            m = 8'($urandom_range(1, 255));
            seq_rand(64);
            for (int k = 0; k < 64; k++) begin
                if ($urandom_range(9) == 0) ev[k] = 8'($urandom);
            end
            ev[40] = ev[40] | m;
            run_capture(p, q, m, 80, (r % 2 == 0) ? 100 : 60, $sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
